// File: rtl/ddc_nco_mixer.sv
`timescale 1ns/1ps
// ddc_nco_mixer: real IF samples mixed to I/Q baseband by a LUT-based NCO, followed by an
// optional 2^DEC_LOG2 integrate-and-dump, round-half-up and saturation to OUT_W bits.
module ddc_nco_mixer #(
  parameter int DATA_W   = 16,
  parameter int OUT_W    = 16,
  parameter int PHASE_W  = 32,
  parameter int LUT_AW   = 10,
  parameter int LUT_W    = 16,
  parameter int DEC_LOG2 = 0,
  parameter logic [PHASE_W-1:0] FCW_RESET = PHASE_W'(32'h4000_0000)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] adc_in,
  input  logic [PHASE_W-1:0]       fcw,
  input  logic [PHASE_W-1:0]       phase_off,
  input  logic                     cfg_load,
  input  logic                     phase_clr,
  output logic signed [OUT_W-1:0]  i_out,
  output logic signed [OUT_W-1:0]  q_out,
  output logic                     out_valid,
  output logic                     sat
);
  localparam int N  = 2 ** LUT_AW;
  localparam int PW = DATA_W + LUT_W;
  localparam int SW = PW + DEC_LOG2;
  localparam int SH = LUT_W - 1 + DEC_LOG2;
  localparam int CW = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam logic [CW-1:0] LAST = CW'((2 ** DEC_LOG2) - 1);
  localparam real PI = 3.14159265358979323846;
  localparam logic signed [SW:0] HALF = (SW+1)'(1) << (SH - 1);
  localparam logic signed [SW:0] OMAX = {{(SW - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [SW:0] OMIN = ~OMAX;

  typedef logic signed [LUT_W-1:0] amp_t;

  function automatic real cos_taylor(input real x);
    real t, s;
    t = 1.0;
    s = 1.0;
    for (int n = 1; n <= 20; n++) begin
      t = -t * x * x / real'((2 * n - 1) * (2 * n));
      s = s + t;
    end
    return s;
  endfunction

  // sin is taken as cos shifted back a quarter turn so one series serves both tables.
  function automatic amp_t lut_val(input int k, input bit is_sin);
    real x, v;
    int  iv;
    x = 2.0 * PI * real'(k - (is_sin ? N / 4 : 0)) / real'(N);
    if (x > PI) x = x - 2.0 * PI;
    v = real'((2 ** (LUT_W - 1)) - 1) * cos_taylor(x);
    iv = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return amp_t'(iv);
  endfunction

  function automatic logic signed [SW:0] rnd(input logic signed [SW-1:0] v);
    logic signed [SW:0] t;
    t = (SW+1)'(v);
    return (t + HALF) >>> SH;
  endfunction

  function automatic logic signed [OUT_W-1:0] clamp(input logic signed [SW:0] r);
    if (r > OMAX) return OMAX[OUT_W-1:0];
    if (r < OMIN) return OMIN[OUT_W-1:0];
    return r[OUT_W-1:0];
  endfunction

  function automatic logic clipped(input logic signed [SW:0] r);
    return (r > OMAX) || (r < OMIN);
  endfunction

  amp_t cos_lut  [N];
  amp_t nsin_lut [N];

  for (genvar k = 0; k < N; k++) begin : g_lut
    localparam amp_t C = lut_val(k, 1'b0);
    localparam amp_t S = lut_val(k, 1'b1);
    assign cos_lut[k]  = C;
    assign nsin_lut[k] = -S;
  end

  logic [PHASE_W-1:0]       acc_q, acc_d, acc_base, fcw_q, off_q;
  logic [LUT_AW-1:0]        idx_d, idx_p0_q;
  logic signed [DATA_W-1:0] x_p0_q, x_p1_q;
  amp_t                     cos_p1_q, nsin_p1_q;
  logic signed [PW-1:0]     prod_i_p2_q, prod_q_p2_q;
  logic                     vld_p0_q, vld_p1_q, vld_p2_q;
  logic                     clr_p0_q, clr_p1_q, clr_p2_q;
  logic [CW-1:0]            cnt_q, cnt_d, cnt_base;
  logic signed [SW-1:0]     sum_i_q, sum_q_q, sum_i_d, sum_q_d;
  logic signed [SW-1:0]     sum_i_base, sum_q_base, tot_i, tot_q;
  logic signed [SW:0]       r_i, r_q;
  logic signed [OUT_W-1:0]  i_q, q_q, i_d, q_d;
  logic                     vld_o_q, vld_o_d, sat_q, sat_d;

  // Phase: a coincident phase_clr makes this sample see acc=0.
  always_comb begin
    acc_base = phase_clr ? '0 : acc_q;
    acc_d    = acc_base;
    if (in_valid) acc_d = acc_base + fcw_q;
  end

  assign idx_d = LUT_AW'((acc_base + off_q) >> (PHASE_W - LUT_AW));

  // Stage 3: accumulate or dump, then round and saturate.
  always_comb begin
    cnt_base   = clr_p2_q ? '0 : cnt_q;
    sum_i_base = clr_p2_q ? '0 : sum_i_q;
    sum_q_base = clr_p2_q ? '0 : sum_q_q;
    tot_i      = sum_i_base + SW'(prod_i_p2_q);
    tot_q      = sum_q_base + SW'(prod_q_p2_q);
    r_i        = rnd(tot_i);
    r_q        = rnd(tot_q);
    cnt_d      = cnt_base;
    sum_i_d    = sum_i_base;
    sum_q_d    = sum_q_base;
    vld_o_d    = 1'b0;
    i_d        = i_q;
    q_d        = q_q;
    sat_d      = sat_q;
    if (vld_p2_q) begin
      if (cnt_base == LAST) begin
        cnt_d   = '0;
        sum_i_d = '0;
        sum_q_d = '0;
        vld_o_d = 1'b1;
        i_d     = clamp(r_i);
        q_d     = clamp(r_q);
        sat_d   = clipped(r_i) || clipped(r_q);
      end else begin
        cnt_d   = cnt_base + CW'(1);
        sum_i_d = tot_i;
        sum_q_d = tot_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      fcw_q    <= FCW_RESET;
      off_q    <= '0;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      clr_p0_q <= 1'b0;
      clr_p1_q <= 1'b0;
      clr_p2_q <= 1'b0;
      cnt_q    <= '0;
      sum_i_q  <= '0;
      sum_q_q  <= '0;
      i_q      <= '0;
      q_q      <= '0;
      vld_o_q  <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (cfg_load) begin
        fcw_q <= fcw;
        off_q <= phase_off;
      end
      vld_p0_q <= in_valid;
      clr_p0_q <= phase_clr;
      vld_p1_q <= vld_p0_q;
      clr_p1_q <= clr_p0_q;
      vld_p2_q <= vld_p1_q;
      clr_p2_q <= clr_p1_q;
      cnt_q    <= cnt_d;
      sum_i_q  <= sum_i_d;
      sum_q_q  <= sum_q_d;
      i_q      <= i_d;
      q_q      <= q_d;
      vld_o_q  <= vld_o_d;
      sat_q    <= sat_d;
    end
  end

  // Stages 0..2 datapath: phase index, LUT read, multiply; loaded only on valid data.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      idx_p0_q <= idx_d;
      x_p0_q   <= adc_in;
    end
    if (vld_p0_q) begin
      cos_p1_q  <= cos_lut[idx_p0_q];
      nsin_p1_q <= nsin_lut[idx_p0_q];
      x_p1_q    <= x_p0_q;
    end
    if (vld_p1_q) begin
      prod_i_p2_q <= PW'(x_p1_q) * PW'(cos_p1_q);
      prod_q_p2_q <= PW'(x_p1_q) * PW'(nsin_p1_q);
    end
  end

  assign i_out     = i_q;
  assign q_out     = q_q;
  assign out_valid = vld_o_q;
  assign sat       = sat_q;
endmodule

// File: tb/tb_ddc_nco_mixer.sv
`timescale 1ns/1ps
// Bench for ddc_nco_mixer: a default-parameter instance and a 12-bit, decimate-by-4 instance
// share one stimulus stream; a reference model feeds per-instance expected-result queues.
module tb_ddc_nco_mixer;
  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] adc_in = '0;
  logic [31:0]        fcw = '0;
  logic [31:0]        phase_off = '0;
  logic               cfg_load = 1'b0;
  logic               phase_clr = 1'b0;
  logic signed [15:0] ia, qa;
  logic signed [11:0] ib, qb;
  logic               va, sa, vb, sb;

  int checks = 0;
  int failures = 0;

  ddc_nco_mixer u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .adc_in(adc_in), .fcw(fcw),
    .phase_off(phase_off), .cfg_load(cfg_load), .phase_clr(phase_clr),
    .i_out(ia), .q_out(qa), .out_valid(va), .sat(sa));

  ddc_nco_mixer #(.OUT_W(12), .DEC_LOG2(2)) u_dec (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .adc_in(adc_in), .fcw(fcw),
    .phase_off(phase_off), .cfg_load(cfg_load), .phase_clr(phase_clr),
    .i_out(ib), .q_out(qb), .out_valid(vb), .sat(sb));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    longint i;
    longint q;
    longint s;
    int     cyc;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t ea, eb;
  int   ecnt = 0;
  int   nb_pulses = 0;
  longint rec_i[8];
  longint rec_q[8];
  int   nrec = 0;

  // Reference model state
  logic [31:0] m_acc, m_fcw, m_off, m_base, m_ph;
  int          m_cnt;
  longint      m_si, m_sq, m_pi, m_pq;

  function automatic longint amp(input int idx, input bit is_sin);
    real a, v;
    a = 2.0 * 3.14159265358979323846 * real'(idx) / 1024.0;
    v = 32767.0 * (is_sin ? $sin(a) : $cos(a));
    return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
  endfunction

  function automatic exp_t mk(input longint si, input longint sq, input int sh, input int ow,
                              input int cyc);
    exp_t   e;
    longint ri, rq, mx, mn;
    ri = (si + (longint'(1) <<< (sh - 1))) >>> sh;
    rq = (sq + (longint'(1) <<< (sh - 1))) >>> sh;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -mx - 1;
    e.s = ((ri > mx) || (ri < mn) || (rq > mx) || (rq < mn)) ? 1 : 0;
    e.i = (ri > mx) ? mx : ((ri < mn) ? mn : ri);
    e.q = (rq > mx) ? mx : ((rq < mn) ? mn : rq);
    e.cyc = cyc;
    return e;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_acc = '0;
      m_fcw = 32'h4000_0000;
      m_off = '0;
      m_cnt = 0;
      m_si  = 0;
      m_sq  = 0;
      exp_a.delete();
      exp_b.delete();
    end else begin
      ecnt++;
      m_base = phase_clr ? 32'h0 : m_acc;
      if (phase_clr) begin
        m_acc = '0;
        m_cnt = 0;
        m_si  = 0;
        m_sq  = 0;
      end
      if (in_valid) begin
        m_ph = m_base + m_off;
        m_pi = longint'(adc_in) * amp(int'(m_ph[31:22]), 1'b0);
        m_pq = -(longint'(adc_in) * amp(int'(m_ph[31:22]), 1'b1));
        exp_a.push_back(mk(m_pi, m_pq, 15, 16, ecnt + 3));
        m_si += m_pi;
        m_sq += m_pq;
        m_cnt++;
        if (m_cnt == 4) begin
          exp_b.push_back(mk(m_si, m_sq, 17, 12, ecnt + 3));
          m_cnt = 0;
          m_si  = 0;
          m_sq  = 0;
        end
        m_acc = m_base + m_fcw;
      end
      if (cfg_load) begin
        m_fcw = fcw;
        m_off = phase_off;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (va) begin
        if (exp_a.size() == 0) check_eq("a_spurious_valid", 1, 0);
        else begin
          ea = exp_a.pop_front();
          check_eq("a_latency", ecnt, ea.cyc);
          check_eq("a_i", ia, ea.i);
          check_eq("a_q", qa, ea.q);
          check_eq("a_sat", sa, ea.s);
        end
        if (nrec < 8) begin
          rec_i[nrec] = ia;
          rec_q[nrec] = qa;
          nrec++;
        end
      end else if (exp_a.size() > 0 && exp_a[0].cyc <= ecnt) begin
        check_eq("a_missing_valid", va, 1);
        void'(exp_a.pop_front());
      end
      if (vb) begin
        nb_pulses++;
        if (exp_b.size() == 0) check_eq("b_spurious_valid", 1, 0);
        else begin
          eb = exp_b.pop_front();
          check_eq("b_latency", ecnt, eb.cyc);
          check_eq("b_i", ib, eb.i);
          check_eq("b_q", qb, eb.q);
          check_eq("b_sat", sb, eb.s);
        end
      end else if (exp_b.size() > 0 && exp_b[0].cyc <= ecnt) begin
        check_eq("b_missing_valid", vb, 1);
        void'(exp_b.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input int x, input bit clr, input bit ld,
                       input logic [31:0] f, input logic [31:0] o);
    in_valid  = v;
    adc_in    = 16'(x);
    phase_clr = clr;
    cfg_load  = ld;
    fcw       = f;
    phase_off = o;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    phase_clr = 1'b0;
    cfg_load  = 1'b0;
  endtask

  task automatic sample(input int x);
    drive(1'b1, x, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint qi_tab[4] = '{1000, 0, -1000, 0};
    longint qq_tab[4] = '{0, -1000, 0, 1000};
    int nb0;

    idle(2);
    check_eq("rst_i", ia, 0);
    check_eq("rst_q", qa, 0);
    check_eq("rst_valid", va, 0);
    check_eq("rst_sat", sa, 0);
    check_eq("rst_dec_valid", vb, 0);
    reset_n = 1'b1;
    idle(1);

    // Quadrature tone at FS/4 with the reset-time frequency word
    for (int k = 0; k < 8; k++) sample(1000);
    idle(5);
    check_eq("quad_count", nrec, 8);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("quad_i%0d", k), rec_i[k], qi_tab[k % 4]);
      check_eq($sformatf("quad_q%0d", k), rec_q[k], qq_tab[k % 4]);
    end

    // Gapped stream, then phase_clr with a coincident sample
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 2) == 0) idle(1 + $urandom_range(0, 2));
      sample(1000);
    end
    drive(1'b1, 1000, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(5);
    check_eq("clr_i", ia, 1000);
    check_eq("clr_q", qa, 0);
    for (int k = 0; k < 9; k++) begin
      if ($urandom_range(0, 1) == 0) idle(1 + $urandom_range(0, 3));
      sample(1000);
    end
    idle(5);

    // Config load with samples numbered from 0: sample 3 still advances by the old fcw
    drive(1'b1, 1000, 1'b1, 1'b0, 32'h0, 32'h0);
    sample(1000);
    sample(1000);
    drive(1'b1, 1000, 1'b0, 1'b1, 32'h0, 32'h8000_0000);
    for (int k = 0; k < 4; k++) sample(1000);
    idle(5);
    check_eq("cfg_i", ia, -1000);
    check_eq("cfg_q", qa, 0);

    // Reset with two samples in flight
    sample(700);
    sample(900);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_i", ia, 0);
    check_eq("midrst_q", qa, 0);
    check_eq("midrst_valid", va, 0);
    check_eq("midrst_dec_i", ib, 0);
    idle(3);
    reset_n = 1'b1;
    idle(5);
    sample(1234);
    idle(5);
    check_eq("post_rst_i", ia, 1234);
    check_eq("post_rst_q", qa, 0);

    // Saturation and decimation on a DC tone (fcw=0), windows aligned by phase_clr
    drive(1'b0, 0, 1'b1, 1'b1, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) sample(4000);
    idle(5);
    check_eq("sat_pos_i", ib, 2047);
    check_eq("sat_pos_q", qb, 0);
    check_eq("sat_pos_flag", sb, 1);
    check_eq("nosat_wide_i", ia, 4000);
    for (int k = 0; k < 4; k++) sample(-4000);
    idle(5);
    check_eq("sat_neg_i", ib, -2048);
    check_eq("sat_neg_flag", sb, 1);
    for (int k = 0; k < 4; k++) sample(1000);
    idle(5);
    check_eq("nosat_i", ib, 1000);
    check_eq("nosat_flag", sb, 0);
    nb0 = nb_pulses;
    for (int k = 0; k < 8; k++) sample((k % 2 == 0) ? 1000 : 3000);
    idle(5);
    check_eq("dec_pulses", nb_pulses - nb0, 2);
    check_eq("dec_i", ib, 2000);
    check_eq("dec_q", qb, 0);

    idle(4);
    check_eq("drain_a", exp_a.size(), 0);
    check_eq("drain_b", exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
